// File: rtl/wbs_ctrl_slave.sv
// rtl/wbs_ctrl_slave.sv - Wishbone B4 classic control slave; best read path gated by WBS_BEST_READ_EN
module wbs_ctrl_slave #(
    parameter int MEM_AW  = 9,
    parameter int NODE_AW = 6,
    parameter int BEST_AW = 9
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [31:0]         wbs_dat_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    output logic                mode_o,
    output logic                debug_o,
    output logic                fsm_start_o,
    input  logic                fsm_done_i,
    input  logic                fsm_busy_i,
    output logic                mem_wen_o,
    output logic                mem_sel_o,
    output logic [MEM_AW-1:0]   mem_addr_o,
    output logic [63:0]         mem_wdata_o,
    output logic                node_wen_o,
    output logic [NODE_AW-1:0]  node_addr_o,
    output logic [21:0]         node_wdata_o,
    output logic                best_ren_o,
    output logic [BEST_AW-1:0]  best_addr_o,
    input  logic [63:0]         best_rdata_i
);

    localparam logic [15:0] REG_CSR   = 16'h3000;
    localparam logic [15:0] REG_QUERY = 16'h3001;
    localparam logic [15:0] REG_LEAF  = 16'h3002;
    localparam logic [15:0] REG_BEST  = 16'h3003;
    localparam logic [15:0] REG_NODE  = 16'h3004;

    localparam logic [15:0] OFF_MODE  = 16'h0000;
    localparam logic [15:0] OFF_DEBUG = 16'h0004;
    localparam logic [15:0] OFF_DONE  = 16'h0008;
    localparam logic [15:0] OFF_START = 16'h000C;
    localparam logic [15:0] OFF_BUSY  = 16'h0010;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACK     = 2'd1,
        ST_RD_WAIT = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic               req;
    logic               accept;
    logic               wr_fire;
    logic               best_rd;
    logic [15:0]        region;
    logic [15:0]        offset;
    logic [31:0]        csr_rdata;

    logic               mode_q, mode_d;
    logic               debug_q, debug_d;
    logic               done_q, done_d;
    logic               start_q, start_d;
    logic [31:0]        hold_q, hold_d;
    logic [31:0]        dat_q, dat_d;
    logic               mem_wen_q, mem_wen_d;
    logic               mem_sel_q, mem_sel_d;
    logic [MEM_AW-1:0]  mem_addr_q, mem_addr_d;
    logic [63:0]        mem_wdata_q, mem_wdata_d;
    logic               node_wen_q, node_wen_d;
    logic [NODE_AW-1:0] node_addr_q, node_addr_d;
    logic [21:0]        node_wdata_q, node_wdata_d;

    assign req     = wbs_cyc_i & wbs_stb_i;
    assign region  = wbs_adr_i[31:16];
    assign offset  = wbs_adr_i[15:0];
    assign accept  = (state_q == ST_IDLE) && req;
    // A write with no byte lanes selected is acked but changes nothing
    assign wr_fire = accept && wbs_we_i && (wbs_sel_i != 4'b0000);

`ifdef WBS_BEST_READ_EN
    logic rd_half_q, rd_half_d;

    assign best_rd     = !wbs_we_i && (region == REG_BEST);
    assign best_ren_o  = accept && best_rd;
    assign best_addr_o = wbs_adr_i[BEST_AW+2:3];
`else
    logic [63:0] unused_best;

    assign best_rd     = 1'b0;
    assign best_ren_o  = 1'b0;
    assign best_addr_o = '0;
    assign unused_best = best_rdata_i;
`endif

    // Bus handshake state: best reads take an extra cycle for memory latency
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = best_rd ? ST_RD_WAIT : ST_ACK;
                end
            end
            ST_RD_WAIT: state_d = req ? ST_ACK : ST_IDLE;
            ST_ACK:     state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Control/status register read mux
    always_comb begin
        csr_rdata = '0;
        case (offset)
            OFF_MODE:  csr_rdata[0] = mode_q;
            OFF_DEBUG: csr_rdata[0] = debug_q;
            OFF_DONE:  csr_rdata[0] = done_q;
            OFF_BUSY:  csr_rdata[0] = fsm_busy_i;
            default:   csr_rdata = '0;
        endcase
    end

    // Next-state of registers and one-cycle side-effect strobes
    always_comb begin
        mode_d       = mode_q;
        debug_d      = debug_q;
        done_d       = done_q;
        hold_d       = hold_q;
        start_d      = 1'b0;
        dat_d        = '0;
        mem_wen_d    = 1'b0;
        mem_sel_d    = mem_sel_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        node_wen_d   = 1'b0;
        node_addr_d  = node_addr_q;
        node_wdata_d = node_wdata_q;
`ifdef WBS_BEST_READ_EN
        rd_half_d    = rd_half_q;
        if (accept && best_rd) begin
            rd_half_d = wbs_adr_i[2];
        end
        if ((state_q == ST_RD_WAIT) && req) begin
            dat_d = rd_half_q ? best_rdata_i[63:32] : best_rdata_i[31:0];
        end
`endif
        if (accept && !wbs_we_i && (region == REG_CSR)) begin
            dat_d = csr_rdata;
        end
        if (wr_fire) begin
            case (region)
                REG_CSR: begin
                    case (offset)
                        OFF_MODE:  mode_d  = wbs_dat_i[0];
                        OFF_DEBUG: debug_d = wbs_dat_i[0];
                        OFF_DONE: begin
                            if (wbs_dat_i[0]) begin
                                done_d = 1'b0;
                            end
                        end
                        OFF_START: start_d = wbs_dat_i[0] & ~fsm_busy_i;
                        default: ;
                    endcase
                end
                REG_QUERY, REG_LEAF: begin
                    if (!wbs_adr_i[2]) begin
                        hold_d = wbs_dat_i;
                    end else begin
                        mem_wen_d   = 1'b1;
                        mem_sel_d   = (region == REG_LEAF);
                        mem_addr_d  = wbs_adr_i[MEM_AW+2:3];
                        mem_wdata_d = {wbs_dat_i, hold_q};
                    end
                end
                REG_NODE: begin
                    node_wen_d   = 1'b1;
                    node_addr_d  = wbs_adr_i[NODE_AW+1:2];
                    node_wdata_d = wbs_dat_i[21:0];
                end
                default: ;
            endcase
        end
        // A done pulse wins over a simultaneous clear
        if (fsm_done_i) begin
            done_d = 1'b1;
        end
    end

    // State register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            mode_q       <= 1'b0;
            debug_q      <= 1'b0;
            done_q       <= 1'b0;
            hold_q       <= '0;
            start_q      <= 1'b0;
            dat_q        <= '0;
            mem_wen_q    <= 1'b0;
            mem_sel_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            node_wen_q   <= 1'b0;
            node_addr_q  <= '0;
            node_wdata_q <= '0;
`ifdef WBS_BEST_READ_EN
            rd_half_q    <= 1'b0;
`endif
        end else begin
            mode_q       <= mode_d;
            debug_q      <= debug_d;
            done_q       <= done_d;
            hold_q       <= hold_d;
            start_q      <= start_d;
            dat_q        <= dat_d;
            mem_wen_q    <= mem_wen_d;
            mem_sel_q    <= mem_sel_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            node_wen_q   <= node_wen_d;
            node_addr_q  <= node_addr_d;
            node_wdata_q <= node_wdata_d;
`ifdef WBS_BEST_READ_EN
            rd_half_q    <= rd_half_d;
`endif
        end
    end

    assign wbs_ack_o    = (state_q == ST_ACK);
    assign wbs_dat_o    = dat_q;
    assign mode_o       = mode_q;
    assign debug_o      = debug_q;
    assign fsm_start_o  = start_q;
    assign mem_wen_o    = mem_wen_q;
    assign mem_sel_o    = mem_sel_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign node_wen_o   = node_wen_q;
    assign node_addr_o  = node_addr_q;
    assign node_wdata_o = node_wdata_q;

endmodule

// File: tb/tb_wbs_ctrl_slave.sv
// tb/tb_wbs_ctrl_slave.sv - scoreboard bench for wbs_ctrl_slave
module tb_wbs_ctrl_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack;
    logic [31:0] rdat;
    logic        mode_o, debug_o, fsm_start_o;
    logic        fsm_done, fsm_busy;
    logic        mem_wen_o, mem_sel_o;
    logic [8:0]  mem_addr_o;
    logic [63:0] mem_wdata_o;
    logic        node_wen_o;
    logic [5:0]  node_addr_o;
    logic [21:0] node_wdata_o;
    logic        best_ren_o;
    logic [8:0]  best_addr_o;
    logic [63:0] best_rdata = '0;

    int checks = 0;
    int errors = 0;
    int cnt = 0;

    typedef struct { logic [31:0] dat; int due; } rd_t;
    typedef struct { logic s; logic [8:0] a; logic [63:0] d; int due; } mw_t;
    typedef struct { logic [5:0] a; logic [21:0] d; int due; } nw_t;

    rd_t rd_q[$];
    mw_t mw_q[$];
    nw_t nw_q[$];
    int  st_q[$];
    rd_t re;
    mw_t me;
    nw_t ne;
    int  se;

    logic        m_mode, m_debug, m_done;
    logic [31:0] m_hold;
    logic        prev_ack = 1'b0;

    wbs_ctrl_slave dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .mode_o(mode_o), .debug_o(debug_o), .fsm_start_o(fsm_start_o),
        .fsm_done_i(fsm_done), .fsm_busy_i(fsm_busy),
        .mem_wen_o(mem_wen_o), .mem_sel_o(mem_sel_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .node_wen_o(node_wen_o), .node_addr_o(node_addr_o), .node_wdata_o(node_wdata_o),
        .best_ren_o(best_ren_o), .best_addr_o(best_addr_o), .best_rdata_i(best_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cnt <= cnt + 1;

    function automatic logic [63:0] bmem(input logic [8:0] a);
        return {32'hDEAD_0000 ^ {23'b0, a}, 32'h0000_0042 + 32'(a) * 32'd7};
    endfunction

    // Best-index memory with one-cycle read latency
    always @(posedge clk) if (best_ren_o) best_rdata <= bmem(best_addr_o);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an ack or strobe
    always @(negedge clk) begin
        if (rst) begin
            prev_ack = 1'b0;
        end else begin
            if (ack) begin
                chk("ack_single_cycle", prev_ack, 0);
                if (rd_q.size() == 0) begin
                    chk("unexpected_ack", 1, 0);
                end else begin
                    re = rd_q.pop_front();
                    chk("rdata", rdat, re.dat);
                    chk("ack_cycle", cnt, re.due);
                end
            end else if (prev_ack) begin
                chk("dat_zero_after_ack", rdat, 0);
            end
            if (mem_wen_o) begin
                if (mw_q.size() == 0) chk("unexpected_mem_wen", 1, 0);
                else begin
                    me = mw_q.pop_front();
                    chk("mem_sel", mem_sel_o, me.s);
                    chk("mem_addr", mem_addr_o, me.a);
                    chk("mem_wdata", mem_wdata_o, me.d);
                    chk("mem_wen_cycle", cnt, me.due);
                end
            end
            if (node_wen_o) begin
                if (nw_q.size() == 0) chk("unexpected_node_wen", 1, 0);
                else begin
                    ne = nw_q.pop_front();
                    chk("node_addr", node_addr_o, ne.a);
                    chk("node_wdata", node_wdata_o, ne.d);
                    chk("node_wen_cycle", cnt, ne.due);
                end
            end
            if (fsm_start_o) begin
                if (st_q.size() == 0) chk("unexpected_start", 1, 0);
                else begin
                    se = st_q.pop_front();
                    chk("start_cycle", cnt, se);
                end
            end
            prev_ack = ack;
        end
    end

    task automatic model_reset();
        m_mode = 0; m_debug = 0; m_done = 0; m_hold = '0;
    endtask

    // One bus transaction; the model predicts its read data, latency and side effects
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic busy, input logic dpulse);
        logic [31:0] exp;
        logic [63:0] b;
        logic [15:0] region;
        int issue;
        int lat;
        @(negedge clk);
        cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s;
        fsm_busy = busy; fsm_done = dpulse;
        issue = cnt;
        lat = 1;
        exp = '0;
        region = a[31:16];
        if (!w) begin
            if (region == 16'h3000) begin
                case (a[15:0])
                    16'h0000: exp = {31'b0, m_mode};
                    16'h0004: exp = {31'b0, m_debug};
                    16'h0008: exp = {31'b0, m_done};
                    16'h0010: exp = {31'b0, busy};
                    default:  exp = '0;
                endcase
            end
`ifdef WBS_BEST_READ_EN
            if (region == 16'h3003) begin
                lat = 2;
                b = bmem(a[11:3]);
                exp = a[2] ? b[63:32] : b[31:0];
            end
`endif
        end else if (s != 4'b0000) begin
            if (region == 16'h3000) begin
                case (a[15:0])
                    16'h0000: m_mode = d[0];
                    16'h0004: m_debug = d[0];
                    16'h0008: if (d[0]) m_done = 0;
                    16'h000C: if (d[0] && !busy) st_q.push_back(issue + 1);
                    default: ;
                endcase
            end else if (region == 16'h3001 || region == 16'h3002) begin
                if (!a[2]) m_hold = d;
                else mw_q.push_back('{region == 16'h3002, a[11:3], {d, m_hold}, issue + 1});
            end else if (region == 16'h3004) begin
                nw_q.push_back('{a[7:2], d[21:0], issue + 1});
            end
        end
        if (dpulse) m_done = 1;
        rd_q.push_back('{exp, issue + lat});
        @(negedge clk);
        fsm_done = 0;
        for (int k = 0; k < 4 && !ack; k++) @(negedge clk);
        if (!ack) begin
            checks++; errors++;
            $display("FAIL ack_timeout actual=no_ack required=ack adr=%h", a);
            rd_q.delete();
        end
        cyc = 0; stb = 0; we = 0; sel = 0;
        chk("mode_o", mode_o, m_mode);
        chk("debug_o", debug_o, m_debug);
    endtask

    task automatic done_pulse();
        @(negedge clk);
        fsm_done = 1;
        @(negedge clk);
        fsm_done = 0;
        m_done = 1;
    endtask

    // Reset asserted one edge after acceptance must kill the transaction
    task automatic reset_mid(input logic w, input logic [31:0] a);
        @(negedge clk);
        cyc = 1; stb = 1; we = w; adr = a; wdat = $urandom; sel = 4'hF;
`ifdef WBS_BEST_READ_EN
        if (!w && a[31:16] == 16'h3003) begin
            #1;
            chk("best_ren_accept", best_ren_o, 1);
            chk("best_addr", best_addr_o, a[11:3]);
        end
`endif
        @(posedge clk);
        #1;
        rst = 1; cyc = 0; stb = 0; we = 0; sel = 0;
        @(negedge clk);
        chk("rst_mid_ack", ack, 0);
        chk("rst_mid_mem_wen", mem_wen_o, 0);
        chk("rst_mid_node_wen", node_wen_o, 0);
        chk("rst_mid_dat", rdat, 0);
        @(negedge clk);
        rst = 0;
        model_reset();
        repeat (3) @(negedge clk);
    endtask

    logic [31:0] ra;
    logic [15:0] rreg;
    int kind;

    initial begin
        rst = 1; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; wdat = 0;
        fsm_done = 0; fsm_busy = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_ack", ack, 0);
        chk("rst_dat", rdat, 0);
        chk("rst_mode", mode_o, 0);
        chk("rst_debug", debug_o, 0);
        chk("rst_start", fsm_start_o, 0);
        chk("rst_mem_wen", mem_wen_o, 0);
        chk("rst_mem_sel", mem_sel_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_mem_wdata", mem_wdata_o, 0);
        chk("rst_node_wen", node_wen_o, 0);
        chk("rst_node_wdata", node_wdata_o, 0);
        chk("rst_best_ren", best_ren_o, 0);
        rst = 0;
        @(negedge clk);

        xfer(1, 32'h3000_0004, 32'h1, 4'hF, 0, 0);
        xfer(0, 32'h3000_0004, 32'h0, 4'hF, 0, 0);
        xfer(1, 32'h3001_000C, 32'h55, 4'hF, 0, 0);
        xfer(1, 32'h3002_0018, 32'h1234_5678, 4'hF, 0, 0);
        xfer(1, 32'h3002_001C, 32'h0000_00AB, 4'hF, 0, 0);
        xfer(1, 32'h3004_0008, {10'b0, 11'd55, 11'd1}, 4'hF, 0, 0);
        done_pulse();
        xfer(0, 32'h3000_0008, 0, 4'hF, 0, 0);
        xfer(1, 32'h3000_0008, 1, 4'hF, 0, 1);
        xfer(0, 32'h3000_0008, 0, 4'hF, 0, 0);
        xfer(1, 32'h3000_0008, 1, 4'hF, 0, 0);
        xfer(0, 32'h3000_0008, 0, 4'hF, 0, 0);
        xfer(1, 32'h3000_000C, 1, 4'hF, 0, 0);
        xfer(1, 32'h3000_000C, 1, 4'hF, 1, 0);
        xfer(0, 32'h3000_0010, 0, 4'hF, 1, 0);
        xfer(1, 32'h3000_0000, 1, 4'h0, 0, 0);
        xfer(0, 32'h3000_0000, 0, 4'hF, 0, 0);
        xfer(0, 32'h3003_0014, 0, 4'hF, 0, 0);
        xfer(0, 32'h7777_0000, 0, 4'hF, 0, 0);

        reset_mid(1, 32'h3001_0004);
        reset_mid(1, 32'h3000_0000);
        reset_mid(0, 32'h3003_0014);

`ifdef WBS_BEST_READ_EN
        // Abandon a best read by dropping strobe while waiting for memory
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; adr = 32'h3003_0020; sel = 4'hF;
        @(negedge clk);
        cyc = 0; stb = 0;
        repeat (3) begin
            @(negedge clk);
            chk("abandon_no_ack", ack, 0);
        end
`endif

        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 9);
            case (kind)
                0, 1, 2: ra = {16'h3000, 11'b0, 3'($urandom_range(0, 5)), 2'b00};
                3:       ra = {16'h3001, 4'h0, 12'($urandom) & 12'hFFC};
                4:       ra = {16'h3002, 4'h0, 12'($urandom) & 12'hFFC};
                5:       ra = {16'h3004, 8'h0, 6'($urandom), 2'b00};
                6, 7:    ra = {16'h3003, 4'h0, 12'($urandom) & 12'hFFC};
                default: begin
                    rreg = 16'h3005 + 16'($urandom_range(0, 200));
                    ra = {rreg, 16'($urandom) & 16'hFFFC};
                end
            endcase
            xfer(1'($urandom), ra, $urandom,
                 ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                 1'($urandom), $urandom_range(0, 5) == 0);
        end

        repeat (4) @(negedge clk);
        chk("rd_queue_empty", rd_q.size(), 0);
        chk("mem_queue_empty", mw_q.size(), 0);
        chk("node_queue_empty", nw_q.size(), 0);
        chk("start_queue_empty", st_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
